pulse_run_classifier: RTL and testbench

//  Parametrised mark/space run-length classifier. Synchronises and

---
 rtl/pulse_run_classifier_pkg.sv | 15 +
 rtl/pulse_run_classifier_line_deglitch.sv | 30 +++
 rtl/pulse_run_classifier.sv | 82 ++++++++
 tb/tb_pulse_run_classifier.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pulse_run_classifier_pkg.sv
// pulse_run_classifier_pkg: FSM states and event codes shared by the run classifier and its bench
package pulse_run_classifier_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;
    typedef enum logic [2:0] {
        EVT_MARK_S  = 3'b000,
        EVT_MARK_L  = 3'b001,
        EVT_SPACE_S = 3'b010,
        EVT_SPACE_L = 3'b011,
        EVT_GAP     = 3'b100
    } evt_code_t;
endpackage

// File: rtl/pulse_run_classifier_line_deglitch.sv
// line_deglitch: synchronises a raw line and accepts a level change only after GLITCH+1 stable cycles
module line_deglitch #(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic st,
    output logic st_toggle
);
    localparam int FW = GLITCH > 0 ? $clog2(GLITCH + 1) : 1;
    logic [SYNC_STAGES-1:0] sync;
    logic [FW-1:0]          fcnt;
    logic                   s;
    assign s         = sync[SYNC_STAGES-1];
    assign st_toggle = (s != st) && (fcnt == FW'(GLITCH));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            fcnt <= '0;
            st   <= 1'b0;
        end else begin
            sync[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            fcnt <= (s == st || st_toggle) ? '0 : fcnt + 1'b1;
            st   <= st_toggle ? s : st;
        end
    end
endmodule

// File: rtl/pulse_run_classifier.sv
// pulse_run_classifier: measures deglitched mark/space runs and emits one classified event per
// completed run, plus a word-gap event when a space outlasts thr_gap.
module pulse_run_classifier
    import pulse_run_classifier_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic [CNT_W-1:0] thr_mark,
    input  logic [CNT_W-1:0] thr_space,
    input  logic [CNT_W-1:0] thr_gap,
    output logic             level,
    output logic             evt_valid,
    output logic [2:0]       evt_code,
    output logic [CNT_W-1:0] evt_len,
    output logic             evt_sat
);
    localparam logic [CNT_W-1:0] RUN_MAX = '1;
    state_t           state, state_nx;
    evt_code_t        code_nx;
    logic             st, st_toggle, sat, gap_hit, fire;
    logic [CNT_W-1:0] run;
    line_deglitch #(
        .SYNC_STAGES(SYNC_STAGES),
        .GLITCH     (GLITCH)
    ) u_deglitch (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .st       (st),
        .st_toggle(st_toggle)
    );
    assign level = st;
    // run counts cycles of the current level; sat remembers that it hit the ceiling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= '0;
            sat <= 1'b0;
        end else begin
            run <= st_toggle ? CNT_W'(1) : (run == RUN_MAX ? run : run + 1'b1);
            sat <= !st_toggle && (sat || run == RUN_MAX);
        end
    end
    assign gap_hit = state == SPACE && thr_gap != '0 && run == thr_gap && !st_toggle;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = st_toggle ? MARK : IDLE;
            MARK:    state_nx = st_toggle ? SPACE : MARK;
            SPACE:   state_nx = st_toggle ? MARK : (gap_hit ? IDLE : SPACE);
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        fire    = gap_hit || (st_toggle && state != IDLE);
        code_nx = state == MARK ? (run >= thr_mark ? EVT_MARK_L : EVT_MARK_S)
                : gap_hit       ? EVT_GAP
                : (run >= thr_space ? EVT_SPACE_L : EVT_SPACE_S);
    end
    // event registers load on the toggle edge so the strobe lands in the first cycle of the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_code  <= 3'b000;
            evt_len   <= '0;
            evt_sat   <= 1'b0;
        end else begin
            evt_valid <= fire;
            evt_code  <= fire ? code_nx : evt_code;
            evt_len   <= fire ? run : evt_len;
            evt_sat   <= fire ? sat : evt_sat;
        end
    end
endmodule

// File: tb/tb_pulse_run_classifier.sv
// tb_pulse_run_classifier: run-level reference model feeding a scoreboard, checked by an event monitor
module tb_pulse_run_classifier;
    import pulse_run_classifier_pkg::*;
    typedef struct {
        logic [2:0] code;
        logic [7:0] len;
        logic       sat;
    } ev_t;
    logic       clk = 1'b0, rst_n = 1'b0, in = 1'b0;
    logic [7:0] thr_mark = 8'd6, thr_space = 8'd6, thr_gap = 8'd20;
    logic       level, evt_valid, evt_sat;
    logic [2:0] evt_code;
    logic [7:0] evt_len;
    ev_t        exp_q[$];
    int         checks = 0, failures = 0;
    bit         active = 0;
    pulse_run_classifier #(
        .CNT_W      (8),
        .SYNC_STAGES(2),
        .GLITCH     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .thr_mark (thr_mark),
        .thr_space(thr_space),
        .thr_gap  (thr_gap),
        .level    (level),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_len  (evt_len),
        .evt_sat  (evt_sat)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        ev_t e;
        if (evt_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got code=%0d len=%0d sat=%0d required none", evt_code, evt_len, evt_sat);
            end else begin
                e = exp_q.pop_front();
                if (evt_code !== e.code || evt_len !== e.len || evt_sat !== e.sat) begin
                    failures++;
                    $display("FAIL event got code=%0d len=%0d sat=%0d required code=%0d len=%0d sat=%0d",
                             evt_code, evt_len, evt_sat, e.code, e.len, e.sat);
                end
            end
        end
    end
    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask
    task automatic hold(logic v, int n);
        in = v;
        repeat (n) @(negedge clk);
    endtask
    task automatic push(logic [2:0] c, int len);
        ev_t e;
        e.code = c;
        e.len  = len > 255 ? 8'd255 : 8'(len);
        e.sat  = len > 255;
        exp_q.push_back(e);
    endtask
    // a mark always ends in a space, so its event is known when the mark is issued
    task automatic run_mark(int len);
        int m = len > 255 ? 255 : len;
        push(m >= int'(thr_mark) ? EVT_MARK_L : EVT_MARK_S, len);
        active = 1;
        hold(1'b1, len);
    endtask
    task automatic run_space(int len, bit then_rise);
        int m = len > 255 ? 255 : len;
        if (active) begin
            if (thr_gap != 0 && len > int'(thr_gap)) begin
                push(EVT_GAP, int'(thr_gap));
                active = 0;
            end else if (then_rise) begin
                push(m >= int'(thr_space) ? EVT_SPACE_L : EVT_SPACE_S, len);
            end
        end
        hold(1'b0, len);
    endtask
    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask
    initial begin
        int lm;
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_len", evt_len, 0);
        check("rst_sat", evt_sat, 0);
        rst_n = 1'b1;
        hold(1'b0, 10);
        run_mark(3);
        run_space(4, 1);
        run_mark(8);
        run_space(30, 0);
        drain("basic");
        check("idle_after_gap", dut.state, IDLE);
        hold(1'b1, 2);
        in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("glitch_level", level, 0);
        end
        hold(1'b0, 10);
        run_mark(300);
        run_space(30, 0);
        drain("saturate");
        thr_gap = 8'd10;
        run_mark(5);
        run_space(10, 1);
        run_mark(6);
        run_space(5, 1);
        run_mark(5);
        run_space(11, 1);
        run_mark(4);
        run_space(25, 0);
        drain("gap_edge");
        hold(1'b1, 5);
        check("level_mid_mark", level, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_level", level, 0);
        check("async_valid", evt_valid, 0);
        check("async_code", evt_code, 0);
        check("async_len", evt_len, 0);
        check("async_sat", evt_sat, 0);
        in     = 1'b0;
        active = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 40);
        drain("after_reset");
        check("idle_after_reset", dut.state, IDLE);
        thr_gap = 8'd0;
        run_mark(4);
        run_space(100, 1);
        run_mark(3);
        thr_gap = 8'd20;
        run_space(30, 0);
        drain("no_gap");
        for (int r = 0; r < 6; r++) begin
            thr_mark  = 8'($urandom_range(0, 20));
            thr_space = 8'($urandom_range(0, 20));
            thr_gap   = 8'($urandom_range(15, 40));
            for (int k = 0; k < 12; k++) begin
                lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(3, 25));
                run_mark(lm);
                run_space(int'($urandom_range(3, int'(thr_gap) + 2)), 1);
            end
            run_mark(int'($urandom_range(3, 25)));
            run_space(int'(thr_gap) + 15, 0);
            drain("random");
            check("idle_random", dut.state, IDLE);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
